// File: rtl/elementwise_mat_mult_seq_if.sv
// Valid/ready bus for the element-wise matrix multiplier.
// The slave modport is the multiplier side and the master modport is the producer/consumer side.
// Matrices are flattened row-major, with element (0,0) in the most significant DW bits.
interface elementwise_mat_mult_seq_if #(
    parameter int DW = 8,
    parameter int N  = 3
);
    logic              in_valid;
    logic              in_ready;
    logic [N*N*DW-1:0] a;
    logic [N*N*DW-1:0] b;
    logic              out_valid;
    logic              out_ready;
    logic [N*N*DW-1:0] res;

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, res
    );

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, res
    );
endinterface

// File: rtl/elementwise_mat_mult_seq.sv
// Multi-cycle Hadamard product C = A .* B of two N x N matrices.
// Each COMPUTE cycle handles LANES elements, so one result takes ceil(N*N/LANES) beats.
// Optional build macro EMUL_SATURATE_EN changes each product to clamp at 2^DW-1 instead of wrapping.
// The same macro adds the sat_flag output.
module elementwise_mat_mult_seq #(
    parameter int DW    = 8,
    parameter int N     = 3,
    parameter int LANES = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    elementwise_mat_mult_seq_if.slave   bus,
    output logic                        busy
`ifdef EMUL_SATURATE_EN
    ,
    output logic                        sat_flag
`endif
);

    localparam int NN = N * N;
    localparam int IW = $clog2(NN + LANES + 1);

    typedef enum logic [1:0] {
        IDLE,
        COMPUTE,
        DONE
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [IW-1:0]   idx;
    logic [NN*DW-1:0] a_reg;
    logic [NN*DW-1:0] b_reg;
    logic [NN*DW-1:0] res_reg;

    logic            accept;
    logic            last_beat;
    int              lane_e   [LANES];
    logic            lane_en  [LANES];
    logic [DW-1:0]   lane_val [LANES];
`ifdef EMUL_SATURATE_EN
    logic [2*DW-1:0] lane_prod [LANES];
    logic            lane_sat  [LANES];
`endif

    // Extract element e (row-major index) from a flattened matrix.
    function automatic logic [DW-1:0] elem(input logic [NN*DW-1:0] m, input int e);
        return m[(NN-1-e)*DW +: DW];
    endfunction

    assign accept        = bus.in_valid && (state == IDLE) && !rst;
    assign last_beat     = (int'(idx) + LANES >= NN);
    assign bus.in_ready  = (state == IDLE) && !rst;
    assign bus.out_valid = (state == DONE);
    assign bus.res       = res_reg;
    assign busy          = (state == COMPUTE) || (state == DONE);

    // State register; reset aborts any operation in progress.
    always_ff @(posedge clk) begin
        // NOTE: Sequential state uses non-blocking assignments, so every register samples pre-edge values.
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        // NOTE: Assign the default first so no path leaves state_nxt unassigned, which would infer a latch.
        state_nxt = state;
        case (state)
            IDLE:    if (accept)                 state_nxt = COMPUTE;
            COMPUTE: if (last_beat)              state_nxt = DONE;
            DONE:    if (bus.out_ready)          state_nxt = IDLE;
            default:                             state_nxt = IDLE;
        endcase
    end

    // Element index: restarts at each accepted operand pair and advances one beat per COMPUTE cycle.
    always_ff @(posedge clk) begin
        if (rst)                    idx <= '0;
        else if (accept)            idx <= '0;
        else if (state == COMPUTE)  idx <= idx + IW'(LANES);
    end

    // Operand capture, which happens only on the input handshake edge.
    always_ff @(posedge clk) begin
        // NOTE: Operand registers carry no reset because they are always written before being read.
        if (accept) begin
            a_reg <= bus.a;
            b_reg <= bus.b;
        end
    end

    // Lane datapath: the element each lane handles this beat, and the product written for it.
    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            lane_e[k]  = int'(idx) + k;
            lane_en[k] = (lane_e[k] < NN);
`ifdef EMUL_SATURATE_EN
            lane_prod[k] = {{DW{1'b0}}, elem(a_reg, lane_en[k] ? lane_e[k] : 0)} *
                           {{DW{1'b0}}, elem(b_reg, lane_en[k] ? lane_e[k] : 0)};
            lane_sat[k]  = |lane_prod[k][2*DW-1:DW];
            lane_val[k]  = lane_sat[k] ? {DW{1'b1}} : lane_prod[k][DW-1:0];
`else
            lane_val[k]  = elem(a_reg, lane_en[k] ? lane_e[k] : 0) *
                           elem(b_reg, lane_en[k] ? lane_e[k] : 0);
`endif
        end
    end

    // Result register: cleared at the start of an operation, then filled one beat at a time.
    always_ff @(posedge clk) begin
        if (rst || accept) begin
            res_reg <= '0;
        end else if (state == COMPUTE) begin
            for (int k = 0; k < LANES; k++) begin
                if (lane_en[k]) res_reg[(NN-1-lane_e[k])*DW +: DW] <= lane_val[k];
            end
        end
    end

`ifdef EMUL_SATURATE_EN
    // Saturation flag: set when any element of the current operation clamps.
    always_ff @(posedge clk) begin
        if (rst || accept) begin
            sat_flag <= 1'b0;
        end else if (state == COMPUTE) begin
            for (int k = 0; k < LANES; k++) begin
                if (lane_en[k] && lane_sat[k]) sat_flag <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_elementwise_mat_mult_seq.sv
// Self-checking bench for elementwise_mat_mult_seq.
// dut1 uses N=3 and LANES=1. dut4 uses N=3 and LANES=4, to cover the partial final beat.
// Expected results come from a scoreboard queue that is filled when operands are driven.
module tb_elementwise_mat_mult_seq;

    typedef logic [71:0] mat_t;
    typedef struct {
        mat_t res;
        bit   sat;
    } exp_t;

    logic clk;
    logic rst;
    logic busy1, busy4;
`ifdef EMUL_SATURATE_EN
    logic sat1, sat4;
`endif

    elementwise_mat_mult_seq_if #(.DW(8), .N(3)) bus1 ();
    elementwise_mat_mult_seq_if #(.DW(8), .N(3)) bus4 ();

    elementwise_mat_mult_seq #(.DW(8), .N(3), .LANES(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1),
        .busy(busy1)
`ifdef EMUL_SATURATE_EN
        ,
        .sat_flag(sat1)
`endif
    );

    elementwise_mat_mult_seq #(.DW(8), .N(3), .LANES(4)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4),
        .busy(busy4)
`ifdef EMUL_SATURATE_EN
        ,
        .sat_flag(sat4)
`endif
    );

    int   n_chk;
    int   n_pass;
    exp_t exp_q[$];
    mat_t last_res;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Matrix with element e (row-major) = base + step*e.
    function automatic mat_t pack_lin(input int base, input int step);
        mat_t m;
        int   v;
        m = '0;
        for (int e = 0; e < 9; e++) begin
            v = base + step * e;
            m[(8-e)*8 +: 8] = v[7:0];
        end
        return m;
    endfunction

    // Reference Hadamard product, computed at full width and then wrapped or clamped.
    function automatic mat_t model(input mat_t a, input mat_t b, output bit sat);
        logic [15:0] p;
        mat_t        r;
        r   = '0;
        sat = 1'b0;
        for (int e = 0; e < 9; e++) begin
            p = 16'(a[(8-e)*8 +: 8]) * 16'(b[(8-e)*8 +: 8]);
`ifdef EMUL_SATURATE_EN
            if (p > 16'd255) begin
                r[(8-e)*8 +: 8] = 8'hFF;
                sat = 1'b1;
            end else begin
                r[(8-e)*8 +: 8] = p[7:0];
            end
`else
            r[(8-e)*8 +: 8] = p[7:0];
`endif
        end
        return r;
    endfunction

    task automatic drive_in(input mat_t a, input mat_t b);
        exp_t x;
        x.res = model(a, b, x.sat);
        exp_q.push_back(x);
        bus1.a        = a;
        bus1.b        = b;
        bus1.in_valid = 1'b1;
    endtask

    // Called at a negedge with operands already driven.
    // Performs the input handshake, times the latency and scores the result.
    task automatic await_result(input string name, input bit keep_valid, input bit scramble);
        int   lat;
        exp_t x;
        n_chk++;
        if (bus1.in_ready !== 1'b1) $display("FAIL %s in_ready before handshake got %b want 1", name, bus1.in_ready);
        else n_pass++;
        @(posedge clk);
        @(negedge clk);
        if (!keep_valid) bus1.in_valid = 1'b0;
        n_chk++;
        if ({busy1, bus1.in_ready, bus1.res} !== {1'b1, 1'b0, 72'h0})
            $display("FAIL %s first compute cycle busy/in_ready/res got %b/%b/%h want 1/0/0", name, busy1, bus1.in_ready, bus1.res);
        else n_pass++;
        lat = 0;
        while (!bus1.out_valid && lat < 64) begin
            if (scramble) begin
                bus1.a = 72'({$urandom(), $urandom(), $urandom()});
                bus1.b = 72'({$urandom(), $urandom(), $urandom()});
            end
            @(negedge clk);
            lat++;
        end
        n_chk++;
        if (lat != 9) $display("FAIL %s latency got %0d want 9", name, lat);
        else n_pass++;
        last_res = bus1.res;
        n_chk++;
        if (exp_q.size() == 0) begin
            $display("FAIL %s scoreboard empty on output", name);
        end else begin
            x = exp_q.pop_front();
            if (bus1.res !== x.res) $display("FAIL %s res got %h want %h", name, bus1.res, x.res);
            else n_pass++;
`ifdef EMUL_SATURATE_EN
            n_chk++;
            if (sat1 !== x.sat) $display("FAIL %s sat_flag got %b want %b", name, sat1, x.sat);
            else n_pass++;
`endif
        end
    endtask

    task automatic release_out(input string name);
        bus1.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus1.out_ready = 1'b0;
        n_chk++;
        if ({bus1.out_valid, bus1.in_ready} !== 2'b01)
            $display("FAIL %s after output handshake out_valid/in_ready got %b/%b want 0/1", name, bus1.out_valid, bus1.in_ready);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus1.in_valid = 1'b0; bus1.out_ready = 1'b0; bus1.a = '0; bus1.b = '0;
        bus4.in_valid = 1'b0; bus4.out_ready = 1'b0; bus4.a = '0; bus4.b = '0;
        @(negedge clk);
        n_chk++;
        if (bus1.in_ready !== 1'b0) $display("FAIL reset in_ready during rst got %b want 0", bus1.in_ready);
        else n_pass++;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_chk++;
        if ({bus1.out_valid, busy1, bus1.res} !== {1'b0, 1'b0, 72'h0})
            $display("FAIL reset out_valid/busy/res got %b/%b/%h want 0/0/0", bus1.out_valid, busy1, bus1.res);
        else n_pass++;
        n_chk++;
        if ({bus4.out_valid, busy4, bus4.res, bus4.in_ready} !== {1'b0, 1'b0, 72'h0, 1'b0})
            $display("FAIL reset dut4 state got %b/%b/%h/%b want 0/0/0/0", bus4.out_valid, busy4, bus4.res, bus4.in_ready);
        else n_pass++;
        rst = 1'b0;
        #1;
        n_chk++;
        if ({bus1.in_ready, bus4.in_ready} !== 2'b11)
            $display("FAIL reset in_ready after release got %b%b want 11", bus1.in_ready, bus4.in_ready);
        else n_pass++;
    endtask

    task automatic test_basic();
        @(negedge clk);
        drive_in(pack_lin(2, 0), pack_lin(1, 1));
        await_result("basic", 1'b0, 1'b0);
        n_chk++;
        if (last_res !== 72'h02_04_06_08_0A_0C_0E_10_12)
            $display("FAIL basic literal res got %h want 020406080a0c0e1012", last_res);
        else n_pass++;
        release_out("basic");
    endtask

    task automatic test_overflow();
        mat_t a, b;
        a = pack_lin(1, 0);
        b = pack_lin(3, 0);
        a[71:64] = 8'd16;  b[71:64] = 8'd16;
        a[7:0]   = 8'd255; b[7:0]   = 8'd2;
        drive_in(a, b);
        await_result("overflow", 1'b0, 1'b0);
        n_chk++;
`ifdef EMUL_SATURATE_EN
        if ({last_res[71:64], last_res[7:0]} !== 16'hFF_FF)
            $display("FAIL overflow corner elements got %h/%h want ff/ff", last_res[71:64], last_res[7:0]);
`else
        if ({last_res[71:64], last_res[7:0]} !== 16'h00_FE)
            $display("FAIL overflow corner elements got %h/%h want 00/fe", last_res[71:64], last_res[7:0]);
`endif
        else n_pass++;
        release_out("overflow");
        drive_in(pack_lin(1, 0), pack_lin(1, 0));
        await_result("overflow_followup", 1'b0, 1'b0);
        release_out("overflow_followup");
    endtask

    task automatic test_backpressure();
        mat_t held;
        drive_in(pack_lin(3, 2), pack_lin(5, 1));
        await_result("backpressure_m1", 1'b1, 1'b1);
        held = bus1.res;
        for (int i = 0; i < 6; i++) begin
            bus1.a = 72'({$urandom(), $urandom(), $urandom()});
            bus1.b = 72'({$urandom(), $urandom(), $urandom()});
            @(negedge clk);
            n_chk++;
            if ({bus1.res, bus1.out_valid, bus1.in_ready} !== {held, 1'b1, 1'b0})
                $display("FAIL backpressure hold cycle %0d res/out_valid/in_ready got %h/%b/%b want %h/1/0",
                         i, bus1.res, bus1.out_valid, bus1.in_ready, held);
            else n_pass++;
        end
        release_out("backpressure_m1");
        drive_in(pack_lin(9, 3), pack_lin(7, 0));
        await_result("backpressure_m2", 1'b0, 1'b0);
        release_out("backpressure_m2");
    endtask

    task automatic test_mid_reset();
        bit seen;
        bus1.a = pack_lin(4, 1);
        bus1.b = pack_lin(6, 0);
        bus1.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus1.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_chk++;
        if ({bus1.out_valid, busy1, bus1.res} !== {1'b0, 1'b0, 72'h0})
            $display("FAIL mid_reset state out_valid/busy/res got %b/%b/%h want 0/0/0", bus1.out_valid, busy1, bus1.res);
        else n_pass++;
        rst = 1'b0;
        #1;
        n_chk++;
        if (bus1.in_ready !== 1'b1) $display("FAIL mid_reset in_ready after rst got %b want 1", bus1.in_ready);
        else n_pass++;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus1.out_valid) seen = 1'b1;
        end
        n_chk++;
        if (seen !== 1'b0) $display("FAIL mid_reset aborted op out_valid got 1 want 0");
        else n_pass++;
        drive_in(pack_lin(4, 1), pack_lin(6, 0));
        await_result("mid_reset_recover", 1'b0, 1'b0);
        release_out("mid_reset_recover");
    endtask

    task automatic test_operand_isolation();
        @(negedge clk);
        drive_in(pack_lin(11, 5), pack_lin(2, 1));
        await_result("isolation", 1'b0, 1'b1);
        release_out("isolation");
    endtask

    task automatic test_partial_beat();
        mat_t a, b, snap, want_snap;
        exp_t x;
        int   lat;
        a = pack_lin(1, 1);
        b = pack_lin(3, 0);
        x.res = model(a, b, x.sat);
        exp_q.push_back(x);
        want_snap = x.res;
        want_snap[7:0] = 8'h00;
        snap = '0;
        @(negedge clk);
        bus4.a = a;
        bus4.b = b;
        bus4.in_valid = 1'b1;
        n_chk++;
        if (bus4.in_ready !== 1'b1) $display("FAIL partial in_ready got %b want 1", bus4.in_ready);
        else n_pass++;
        @(posedge clk);
        @(negedge clk);
        bus4.in_valid = 1'b0;
        lat = 0;
        while (!bus4.out_valid && lat < 64) begin
            @(negedge clk);
            lat++;
            if (lat == 2) snap = bus4.res;
        end
        n_chk++;
        if (lat != 3) $display("FAIL partial latency got %0d want 3", lat);
        else n_pass++;
        n_chk++;
        if (snap !== want_snap) $display("FAIL partial after two beats res got %h want %h", snap, want_snap);
        else n_pass++;
        x = exp_q.pop_front();
        n_chk++;
        if (bus4.res !== x.res) $display("FAIL partial res got %h want %h", bus4.res, x.res);
        else n_pass++;
        n_chk++;
        if (bus4.res !== 72'h03_06_09_0C_0F_12_15_18_1B)
            $display("FAIL partial literal res got %h want 0306090c0f1215181b", bus4.res);
        else n_pass++;
        bus4.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus4.out_ready = 1'b0;
        n_chk++;
        if ({bus4.out_valid, bus4.in_ready} !== 2'b01)
            $display("FAIL partial release out_valid/in_ready got %b/%b want 0/1", bus4.out_valid, bus4.in_ready);
        else n_pass++;
    endtask

    initial begin
        n_chk  = 0;
        n_pass = 0;
        test_reset();
        test_basic();
        test_overflow();
        test_backpressure();
        test_mid_reset();
        test_operand_isolation();
        test_partial_beat();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
